// File: rtl/div_unit.sv
// Multi-cycle 32-bit DIV/DIVU unit for the E stage: restoring division, one
// quotient bit per cycle, with pipeline stall, annul and divide-by-zero handling.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opa_i,
  input  logic [31:0] opb_i,
  input  logic        annul_i,
  output logic        stall_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [32:0] rem_q, rem_d;
  // Holds the dividend at start; quotient bits shift in from the right as dividend bits leave.
  logic [31:0] dvd_q, dvd_d;
  logic [31:0] dvs_q, dvs_d;
  logic        q_neg_q, q_neg_d;
  logic        r_neg_q, r_neg_d;
  logic [63:0] result_q, result_d;

  logic [32:0] rem_sh;
  logic [33:0] diff;
  logic        step_ok;
  logic [32:0] rem_nx;
  logic [31:0] quo_nx;
  logic        accept;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;

    accept  = start_i & ~annul_i;
    rem_sh  = {rem_q[31:0], dvd_q[31]};
    diff    = {1'b0, rem_sh} - {2'b00, dvs_q};
    step_ok = ~diff[33];
    rem_nx  = step_ok ? diff[32:0] : rem_sh;
    quo_nx  = {dvd_q[30:0], step_ok};

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (opb_i == 32'd0) begin
            result_d = {opa_i, 32'hFFFF_FFFF};
            state_d  = DONE;
          end else begin
            dvd_d   = (signed_i & opa_i[31]) ? -opa_i : opa_i;
            dvs_d   = (signed_i & opb_i[31]) ? -opb_i : opb_i;
            q_neg_d = (opa_i[31] ^ opb_i[31]) & signed_i;
            r_neg_d = opa_i[31] & signed_i;
            rem_d   = 33'd0;
            cnt_d   = 5'd0;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (annul_i) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_nx;
          dvd_d = quo_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            result_d = {r_neg_q ? -rem_nx[31:0] : rem_nx[31:0],
                        q_neg_q ? -quo_nx       : quo_nx};
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      rem_q    <= 33'd0;
      dvd_q    <= 32'd0;
      dvs_q    <= 32'd0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= 64'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
    end
  end

  // Outputs are gated by rst so they drop the moment reset rises, not at the next edge.
  assign stall_o  = ~rst & ~annul_i &
                    (((state_q == IDLE) & start_i) | (state_q == BUSY));
  assign ready_o  = ~rst & ~annul_i & (state_q == DONE);
  assign result_o = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases, randomized operands
// against an arithmetic reference, annul, asynchronous reset and back-to-back ops.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        signed_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        annul_i;
  logic        stall_o;
  logic        ready_o;
  logic [63:0] result_o;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .signed_i (signed_i),
    .opa_i    (opa_i),
    .opb_i    (opb_i),
    .annul_i  (annul_i),
    .stall_o  (stall_o),
    .ready_o  (ready_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  // Reference: plain integer arithmetic, truncating toward zero.
  function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {ur, uq};
  endfunction

  // Issues one divide, holds start_i like a stalled pipeline, scrambles the
  // operands after acceptance, and checks stall timing, latency and result.
  task automatic run_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int  lat;
    bit  seen;
    logic exp_stall;
    lat  = (b == 32'd0) ? 1 : 33;
    seen = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = s; opa_i = a; opb_i = b;
    for (int n = 0; n <= 40 && !seen; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
        opa_i = $urandom; opb_i = $urandom; signed_i = 1'($urandom);
      end
      @(negedge clk);
      exp_stall = (n < lat);
      n_tests++;
      if (stall_o !== exp_stall) begin
        n_fail++;
        $display("FAIL %s stall cycle %0d: got %b want %b", name, n, stall_o, exp_stall);
      end
      if (ready_o === 1'b1) begin
        seen = 1'b1;
        n_tests++;
        if (n != lat) begin
          n_fail++;
          $display("FAIL %s latency: got %0d want %0d", name, n, lat);
        end
        n_tests++;
        if (result_o !== exp) begin
          n_fail++;
          $display("FAIL %s result: got %h want %h", name, result_o, exp);
        end
      end
    end
    start_i = 1'b0;
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got no ready want ready at cycle %0d", name, lat);
    end
    @(negedge clk);
    n_tests++;
    if (ready_o !== 1'b0 || result_o !== exp) begin
      n_fail++;
      $display("FAIL %s hold: got ready=%b result=%h want ready=0 result=%h",
               name, ready_o, result_o, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd1; opb_i = 32'd1; annul_i = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: got stall=%b ready=%b result=%h want 0 0 0",
               stall_o, ready_o, result_o);
    end
    start_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_op(1'b0, 32'd100,       32'd7,        {32'h0000_0002, 32'h0000_000E}, "divu_100_7");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    run_op(1'b1, 32'd7,         32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, "div_7_m2");
    run_op(1'b1, 32'd5,         32'd0,        {32'h0000_0005, 32'hFFFF_FFFF}, "div_5_0");
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, "div_min_m1");
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1,        {32'h0000_0000, 32'hFFFF_FFFF}, "divu_max_1");
    run_op(1'b1, 32'hFFFF_FFF9, 32'd0,        {32'hFFFF_FFF9, 32'hFFFF_FFFF}, "div_neg_0");
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic        s;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom;
      s = 1'($urandom);
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = b >> $urandom_range(8, 31);
        2: a = 32'h8000_0000;
        3: b = 32'hFFFF_FFFF;
        default: ;
      endcase
      run_op(s, a, b, ref_div(s, a, b), $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_annul();
    logic [63:0] prev;
    bit          got_ready;
    prev = result_o;
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    repeat (10) begin @(posedge clk); #1; end
    annul_i = 1'b1;
    @(negedge clk);
    n_tests++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL annul same cycle: got stall=%b ready=%b want 0 0", stall_o, ready_o);
    end
    @(posedge clk); #1;
    annul_i = 1'b0; start_i = 1'b0;
    @(negedge clk);
    n_tests++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL annul idle: got stall=%b want 0", stall_o);
    end
    got_ready = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o === 1'b1) got_ready = 1'b1;
    end
    n_tests++;
    if (got_ready || result_o !== prev) begin
      n_fail++;
      $display("FAIL annul no ready: got ready_seen=%b result=%h want 0 %h",
               got_ready, result_o, prev);
    end
    run_op(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, "divu_9_3_after_annul");
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    start_i = 1'b1; signed_i = 1'b0; opa_i = 32'd100; opb_i = 32'd7;
    repeat (20) begin @(posedge clk); #1; end
    #2;
    rst = 1'b1;
    #1;
    n_tests++;
    if (stall_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin
      n_fail++;
      $display("FAIL async reset: got stall=%b ready=%b result=%h want 0 0 0",
               stall_o, ready_o, result_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    rst = 1'b0;
    run_op(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, "divu_100_7_after_rst");
  endtask

  task automatic test_back_to_back();
    run_op(1'b1, 32'hFFFF_FF9C, 32'd7, ref_div(1'b1, 32'hFFFF_FF9C, 32'd7), "b2b_a");
    run_op(1'b0, 32'd12345678,  32'd0, ref_div(1'b0, 32'd12345678,  32'd0), "b2b_b");
    run_op(1'b1, 32'd1000,      32'hFFFF_FFF6, ref_div(1'b1, 32'd1000, 32'hFFFF_FFF6), "b2b_c");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_annul();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
